// File: rtl/bmp_ram_writer_if.sv
// Byte-stream write bus into bmp_ram_writer: the source presents bytes and the writer reports readiness
// and the address the next accepted byte will be stored at.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 18
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

interface bmp_ram_writer_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int BYTE_WIDTH = `BYTE_WIDTH
);
    logic                  wr_valid;
    logic [BYTE_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready,
        input  wr_addr
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready,
        output wr_addr
    );
endinterface

// File: rtl/bmp_ram_writer.sv
// Streams one complete BMP image (header + pixels) byte by byte into on-chip storage.
// Optional macro BMP_RAM_WRITER_READBACK_EN adds a synchronous read port into the image storage.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 18
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif
`ifndef BMP_TOTAL_SIZE
`define BMP_TOTAL_SIZE 196662
`endif

module bmp_ram_writer #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int BYTE_WIDTH = `BYTE_WIDTH,
    parameter int TOTAL_SIZE = `BMP_TOTAL_SIZE,
    parameter int HDR_SIZE   = 54
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    bmp_ram_writer_if.slave       wr,
    output logic                  in_header_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o
`ifdef BMP_RAM_WRITER_READBACK_EN
    ,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [BYTE_WIDTH-1:0] rd_data_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] HDR_ADDR  = ADDR_WIDTH'(HDR_SIZE);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wrAddr_q;
    logic                  overflow_q;
    logic                  xfer;

    logic [BYTE_WIDTH-1:0] mem [0:TOTAL_SIZE-1];

    assign wr.wr_ready  = (state_q == WRITE);
    assign wr.wr_addr   = wrAddr_q;
    assign xfer         = wr.wr_valid && wr.wr_ready;
    assign busy_o       = (state_q == WRITE);
    assign done_o       = (state_q == DONE);
    assign overflow_o   = overflow_q;
    assign in_header_o  = (state_q == WRITE) && (wrAddr_q < HDR_ADDR);

    // A start pulse wins over everything else: it restarts the address and clears the sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wrAddr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (start_i) begin
                overflow_q <= 1'b0;
            end else if (wr.wr_valid && (state_q != WRITE)) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q  <= WRITE;
                        wrAddr_q <= '0;
                    end
                end
                WRITE: begin
                    if (start_i) begin
                        wrAddr_q <= '0;
                    end else if (xfer) begin
                        if (wrAddr_q == LAST_ADDR) begin
                            state_q <= DONE;
                        end else begin
                            wrAddr_q <= wrAddr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wrAddr_q <= '0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset so an abandoned image keeps whatever was already written.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[wrAddr_q] <= wr.wr_data;
        end
    end

`ifdef BMP_RAM_WRITER_READBACK_EN
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end
`endif

endmodule

// File: tb/tb_bmp_ram_writer.sv
// Directed bench for bmp_ram_writer: a vector table for the handshake start-up plus
// hand-written sequences for full streams, restart, overflow and mid-stream reset.
module tb_bmp_ram_writer;

    localparam int AW = 10;
    localparam int BW = 8;
    localparam int TS = 600;
    localparam int HS = 54;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic inHeader;
    logic busy;
    logic done;
    logic overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bmp_ram_writer_if #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) wrBus ();

`ifdef BMP_RAM_WRITER_READBACK_EN
    logic          rdEn   = 1'b0;
    logic [AW-1:0] rdAddr = '0;
    logic [BW-1:0] rdData;
`endif

    bmp_ram_writer #(
        .ADDR_WIDTH (AW),
        .BYTE_WIDTH (BW),
        .TOTAL_SIZE (TS),
        .HDR_SIZE   (HS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .wr          (wrBus),
        .in_header_o (inHeader),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (overflow)
`ifdef BMP_RAM_WRITER_READBACK_EN
        ,
        .rd_en_i     (rdEn),
        .rd_addr_i   (rdAddr),
        .rd_data_o   (rdData)
`endif
    );

    typedef struct {
        logic          start;
        logic          valid;
        logic [7:0]    data;
        logic          expReady;
        logic [AW-1:0] expAddr;
        logic          expBusy;
        logic          expDone;
        logic          expHdr;
        logic          expOvf;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic valid, input logic [7:0] data);
        start          = st;
        wrBus.wr_valid = valid;
        wrBus.wr_data  = data;
    endtask

    // Streams bytes with wr_valid held high from WRITE at address 0 until done, data = address.
    task automatic runStream(input string tag);
        int expAddr   = 0;
        int readyCnt  = 0;
        int cyc       = 0;
        while (!done && cyc < 1000) begin
            applyStimulus(1'b0, 1'b1, expAddr[7:0]);
            if (wrBus.wr_ready) readyCnt++;
            checkOutput({tag, ".addr"}, 32'(wrBus.wr_addr), expAddr);
            checkOutput({tag, ".hdr"}, 32'(inHeader), 32'(expAddr < HS));
            tick();
            if (expAddr < TS - 1) expAddr++;
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput({tag, ".readyCycles"}, readyCnt, TS);
        checkOutput({tag, ".done"}, 32'(done), 1);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".ready"}, 32'(wrBus.wr_ready), 0);
        checkOutput({tag, ".lastAddr"}, 32'(wrBus.wr_addr), TS - 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset state
        tick();
        tick();
        checkOutput("rst.ready", 32'(wrBus.wr_ready), 0);
        checkOutput("rst.addr", 32'(wrBus.wr_addr), 0);
        checkOutput("rst.busy", 32'(busy), 0);
        checkOutput("rst.done", 32'(done), 0);
        checkOutput("rst.hdr", 32'(inHeader), 0);
        checkOutput("rst.ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        //              start valid data   ready addr    busy  done  hdr   ovf
        vecs[0]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 10'd1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h01, 1'b1, 10'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 10'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h02, 1'b1, 10'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h03, 1'b1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].data);
            tick();
            checkOutput($sformatf("vec%0d.ready", i), 32'(wrBus.wr_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d.addr", i), 32'(wrBus.wr_addr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].expDone));
            checkOutput($sformatf("vec%0d.hdr", i), 32'(inHeader), 32'(vecs[i].expHdr));
            checkOutput($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vecs[i].expOvf));
        end
        checkOutput("vec.mem1", 32'(dut.mem[1]), 32'h01);
        checkOutput("vec.mem3", 32'(dut.mem[3]), 32'h03);

        // Full constant-valid stream
        runStream("full");
        checkOutput("full.mem0", 32'(dut.mem[0]), 32'h00);
        checkOutput("full.mem53", 32'(dut.mem[53]), 32'h35);
        checkOutput("full.mem54", 32'(dut.mem[54]), 32'h36);
        checkOutput("full.mem599", 32'(dut.mem[599]), 32'h57);

        // Byte offered in DONE, then restart with a byte still offered
        applyStimulus(1'b0, 1'b1, 8'hAA);
        tick();
        checkOutput("doneOvf.ovf", 32'(overflow), 1);
        checkOutput("doneOvf.done", 32'(done), 1);
        checkOutput("doneOvf.mem599", 32'(dut.mem[599]), 32'h57);
        checkOutput("doneOvf.mem0", 32'(dut.mem[0]), 32'h00);
        applyStimulus(1'b1, 1'b1, 8'hAA);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("restart.ovf", 32'(overflow), 0);
        checkOutput("restart.addr", 32'(wrBus.wr_addr), 0);
        checkOutput("restart.busy", 32'(busy), 1);
        checkOutput("restart.done", 32'(done), 0);
        checkOutput("restart.mem599", 32'(dut.mem[599]), 32'h57);

        // Restart while a transfer is in flight at address 100
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b1, ~8'(i));
            tick();
        end
        checkOutput("mid.addr100", 32'(wrBus.wr_addr), 100);
        applyStimulus(1'b1, 1'b1, 8'h5C);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("mid.addr0", 32'(wrBus.wr_addr), 0);
        checkOutput("mid.busy", 32'(busy), 1);
        checkOutput("mid.mem100", 32'(dut.mem[100]), 32'h5C);
        checkOutput("mid.mem99", 32'(dut.mem[99]), 32'h9C);
        runStream("mid");
        checkOutput("mid.mem100new", 32'(dut.mem[100]), 32'h64);

        // Reset dropped at address 500
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i));
            tick();
        end
        checkOutput("arst.preAddr", 32'(wrBus.wr_addr), 500);
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        checkOutput("arst.ready", 32'(wrBus.wr_ready), 0);
        checkOutput("arst.addr", 32'(wrBus.wr_addr), 0);
        checkOutput("arst.busy", 32'(busy), 0);
        checkOutput("arst.done", 32'(done), 0);
        checkOutput("arst.hdr", 32'(inHeader), 0);
        checkOutput("arst.ovf", 32'(overflow), 0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 8'hEE);
        tick();
        checkOutput("arst.ovfAfter", 32'(overflow), 1);
        checkOutput("arst.busyAfter", 32'(busy), 0);
        checkOutput("arst.mem0", 32'(dut.mem[0]), 32'h00);
        checkOutput("arst.mem499", 32'(dut.mem[499]), 32'hF3);
        applyStimulus(1'b1, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("arst.ovfCleared", 32'(overflow), 0);
        checkOutput("arst.busyStart", 32'(busy), 1);

`ifdef BMP_RAM_WRITER_READBACK_EN
        rdEn   = 1'b1;
        rdAddr = 10'd0;
        tick();
        checkOutput("rd.addr0", 32'(rdData), 32'h00);
        rdAddr = 10'd54;
        tick();
        checkOutput("rd.addr54", 32'(rdData), 32'h36);
        rdAddr = 10'(TS - 1);
        tick();
        checkOutput("rd.addrLast", 32'(rdData), 32'h57);
        rdAddr = 10'd0;
        applyStimulus(1'b0, 1'b1, 8'h99);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rd.sameCycleOld", 32'(rdData), 32'h00);
        tick();
        checkOutput("rd.newData", 32'(rdData), 32'h99);
        rdEn   = 1'b0;
        rdAddr = 10'd54;
        tick();
        checkOutput("rd.hold", 32'(rdData), 32'h99);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bmp_ram_writer.md
BMP_RAM_WRITER -- requirements
Module: bmp_ram_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH, byte address width.
REQ-002 SHALL have parameter BYTE_WIDTH, default `BYTE_WIDTH, data width per stored byte.
REQ-003 SHALL have parameter TOTAL_SIZE, default `BMP_TOTAL_SIZE, number of bytes in one complete BMP image.
REQ-004 SHALL have parameter HDR_SIZE, default 54, number of BMP header bytes.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  begins or restarts an image write sequence.
REQ-008 wr_valid  input  1  source presents a byte on wr_data.
REQ-009 wr_data  input  BYTE_WIDTH  byte to store.
REQ-010 wr_ready  output  1  block accepts a byte this cycle.
REQ-011 wr_addr  output  ADDR_WIDTH  address the next accepted byte is written to.
REQ-012 in_header  output  1  high while wr_addr < HDR_SIZE in WRITE.
REQ-013 busy  output  1  high in WRITE state.
REQ-014 done  output  1  high in DONE state.
REQ-015 overflow  output  1  sticky error: byte offered while not in WRITE.

Function
REQ-016 SHALL hold storage mem[0:TOTAL_SIZE-1] of BYTE_WIDTH bits; contents not reset.
REQ-017 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-018 IDLE: wr_ready=0; start=1 -> WRITE next cycle, wr_addr<=0.
REQ-019 WRITE: wr_ready=1; transfer occurs when wr_valid && wr_ready on a rising edge.
REQ-020 On transfer mem[wr_addr]<=wr_data and wr_addr<=wr_addr+1, single-cycle write, no back-pressure stalls.
REQ-021 Transfer at wr_addr==TOTAL_SIZE-1 -> DONE next cycle; wr_addr holds TOTAL_SIZE-1 (no wrap).
REQ-022 DONE: wr_ready=0, done=1; start=1 -> WRITE with wr_addr<=0, done falls next cycle.
REQ-023 start=1 in WRITE SHALL restart: wr_addr<=0, any same-cycle transfer is written at the old address, then address is overridden to 0.
REQ-024 wr_valid=1 while state is IDLE or DONE SHALL set overflow=1 and SHALL NOT modify mem.
REQ-025 overflow SHALL clear only on a cycle where start=1 is sampled (start has priority over same-cycle set).
REQ-026 in_header SHALL be combinational from state and wr_addr.
REQ-027 wr_addr SHALL be exactly ADDR_WIDTH bits; TOTAL_SIZE SHALL be <= 2**ADDR_WIDTH.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, wr_addr=0, overflow=0, hence wr_ready=0, busy=0, done=0, in_header=0.
REQ-029 Reset mid-WRITE SHALL abandon the sequence; mem contents already written remain.
REQ-030 First transfer after reset release SHALL require a start pulse.

Configuration
REQ-031 Macro BMP_RAM_WRITER_READBACK_EN SHALL add ports rd_en (input 1), rd_addr (input ADDR_WIDTH), rd_data (output reg BYTE_WIDTH).
REQ-032 With macro: rd_en=1 SHALL load rd_data<=mem[rd_addr] on next rising edge (1-cycle latency), rd_data holds otherwise; same-address read and write in one cycle returns old data; rd_data not reset.
REQ-033 Without macro: no read ports, no read logic; all other behaviour identical.

Verification
REQ-034 Reset, start, stream TOTAL_SIZE bytes with wr_valid constant 1 -> wr_ready high exactly TOTAL_SIZE cycles, done=1 the cycle after last transfer, busy=0.
REQ-035 During stream, in_header=1 for wr_addr 0..53 and 0 from wr_addr=54; wr_valid gaps of 1-3 cycles -> wr_addr only advances on transfers.
REQ-036 In DONE drive wr_valid=1, wr_data=8'hAA -> overflow=1, mem unchanged; then start=1 -> overflow=0, wr_addr=0, busy=1.
REQ-037 Assert start at wr_addr=100 mid-stream -> byte at 100 written, wr_addr=0 next cycle, sequence completes after TOTAL_SIZE further transfers.
REQ-038 Drop rst_n at wr_addr=500 -> outputs at reset values without a clock edge; wr_valid after release without start sets overflow.
REQ-039 With BMP_RAM_WRITER_READBACK_EN, write pattern mem[i]=i[7:0], read addresses 0, 54, TOTAL_SIZE-1 -> rd_data 8'h00, 8'h36, (TOTAL_SIZE-1)[7:0] one cycle after rd_en.
